// File: rtl/ucsbece154b_bpred_ctrl_pkg.sv
// Shared opcodes, FSM state constants and decode helpers for the branch-prediction controller.
package ucsbece154b_bpred_ctrl_pkg;

    localparam logic [6:0] instr_branch_op = 7'b1100011;
    localparam logic [6:0] instr_jal_op    = 7'b1101111;
    localparam logic [6:0] instr_jalr_op   = 7'b1100111;

    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    function automatic logic is_branch(input logic [6:0] op);
        return op == instr_branch_op;
    endfunction

    function automatic logic is_jump(input logic [6:0] op);
        return (op == instr_jal_op) || (op == instr_jalr_op);
    endfunction

endpackage

// File: rtl/ucsbece154b_bpred_ctrl_meta_reg.sv
// Prediction-metadata pipeline register with load enable and clear (clear wins).
module ucsbece154b_bpred_meta_reg #(
    parameter int unsigned IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_valid,
    input  logic [31:0]      i_pc,
    input  logic             i_taken,
    input  logic [31:0]      i_target,
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_valid,
    output logic [31:0]      o_pc,
    output logic             o_taken,
    output logic [31:0]      o_target,
    output logic [IDX_W-1:0] o_idx
);

    logic             r_valid;
    logic [31:0]      r_pc;
    logic             r_taken;
    logic [31:0]      r_target;
    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_pc     <= '0;
            r_taken  <= 1'b0;
            r_target <= '0;
            r_idx    <= '0;
        end else if (i_clr) begin
            r_valid  <= 1'b0;
            r_pc     <= '0;
            r_taken  <= 1'b0;
            r_target <= '0;
            r_idx    <= '0;
        end else if (i_en) begin
            r_valid  <= i_valid;
            r_pc     <= i_pc;
            r_taken  <= i_taken;
            r_target <= i_target;
            r_idx    <= i_idx;
        end
    end

    assign o_valid  = r_valid;
    assign o_pc     = r_pc;
    assign o_taken  = r_taken;
    assign o_target = r_target;
    assign o_idx    = r_idx;

endmodule

// File: rtl/ucsbece154b_bpred_ctrl.sv
// Branch-prediction sequencer: carries prediction metadata to Execute, detects mispredicts,
// drives redirect/flush and all PHT/BTB/GHR writes. Optional counters under BPRED_STATS_EN.
module ucsbece154b_bpred_ctrl
    import ucsbece154b_bpred_ctrl_pkg::*;
#(
    parameter int unsigned NUM_BTB_ENTRIES = 32,
    parameter int unsigned NUM_GHR_BITS    = 5
) (
    input  logic                               clk,
    input  logic                               reset_i,
    input  logic [31:0]                        pcF_i,
    input  logic                               BranchTakenF_i,
    input  logic [31:0]                        BTBtargetF_i,
    input  logic [NUM_GHR_BITS-1:0]            PHTreadaddressF_i,
    input  logic                               StallD_i,
    input  logic                               FlushE_i,
    input  logic [6:0]                         opE_i,
    input  logic                               ActualTakenE_i,
    input  logic [31:0]                        ActualTargetE_i,
    output logic [31:0]                        PCNextF_o,
    output logic                               MispredictE_o,
    output logic                               FlushD_o,
    output logic                               FlushE_o,
    output logic                               PHTwe_o,
    output logic                               PHTincrement_o,
    output logic [NUM_GHR_BITS-1:0]            PHTwriteaddress_o,
    output logic                               BTB_we_o,
    output logic [$clog2(NUM_BTB_ENTRIES)-1:0] BTBwriteaddress_o,
    output logic [31:0]                        BTBwritedata_o,
    output logic                               GHRreset_o
`ifdef BPRED_STATS_EN
    ,
    output logic [31:0]                        branchCount_o,
    output logic [31:0]                        mispredCount_o
`endif
);

    localparam int unsigned BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);

    logic [1:0]              r_state;
    logic                    w_run;

    logic                    w_validD;
    logic [31:0]             w_pcD;
    logic                    w_takenD;
    logic [31:0]             w_targetD;
    logic [NUM_GHR_BITS-1:0] w_idxD;

    logic                    w_validE;
    logic [31:0]             w_pcE;
    logic                    w_takenE;
    logic [31:0]             w_targetE;
    logic [NUM_GHR_BITS-1:0] w_idxE;

    logic                    w_branchE;
    logic                    w_jumpE;
    logic                    w_ctrlE;
    logic                    w_mispredict;
    logic                    w_fd_en;
    logic                    w_de_clr;

    assign w_run     = (r_state == ST_RUN);
    assign w_branchE = is_branch(opE_i);
    assign w_jumpE   = is_jump(opE_i);
    assign w_ctrlE   = w_branchE | w_jumpE;

    // Target mismatch only matters when both sides agree the transfer is taken.
    assign w_mispredict = w_run & w_validE & w_ctrlE &
                          ((w_takenE != ActualTakenE_i) |
                           (w_takenE & ActualTakenE_i & (w_targetE != ActualTargetE_i)));

    assign MispredictE_o = w_mispredict;
    assign FlushD_o      = w_mispredict;
    assign FlushE_o      = w_mispredict | FlushE_i;

    // A redirect must reach D even while the hazard unit requests a stall.
    assign w_fd_en  = ~StallD_i | w_mispredict;
    assign w_de_clr = FlushE_o | StallD_i;

    ucsbece154b_bpred_meta_reg #(
        .IDX_W (NUM_GHR_BITS)
    ) u_meta_fd (
        .clk      (clk),
        .rst      (reset_i),
        .i_en     (w_fd_en),
        .i_clr    (FlushD_o),
        .i_valid  (1'b1),
        .i_pc     (pcF_i),
        .i_taken  (BranchTakenF_i),
        .i_target (BTBtargetF_i),
        .i_idx    (PHTreadaddressF_i),
        .o_valid  (w_validD),
        .o_pc     (w_pcD),
        .o_taken  (w_takenD),
        .o_target (w_targetD),
        .o_idx    (w_idxD)
    );

    ucsbece154b_bpred_meta_reg #(
        .IDX_W (NUM_GHR_BITS)
    ) u_meta_de (
        .clk      (clk),
        .rst      (reset_i),
        .i_en     (1'b1),
        .i_clr    (w_de_clr),
        .i_valid  (w_validD),
        .i_pc     (w_pcD),
        .i_taken  (w_takenD),
        .i_target (w_targetD),
        .i_idx    (w_idxD),
        .o_valid  (w_validE),
        .o_pc     (w_pcE),
        .o_taken  (w_takenE),
        .o_target (w_targetE),
        .o_idx    (w_idxE)
    );

    always_comb begin
        PCNextF_o = pcF_i + 32'd4;
        if (w_mispredict) begin
            PCNextF_o = ActualTakenE_i ? ActualTargetE_i : (w_pcE + 32'd4);
        end else if (BranchTakenF_i) begin
            PCNextF_o = BTBtargetF_i;
        end
    end

    assign PHTwe_o           = w_run & w_validE & w_branchE;
    assign PHTincrement_o    = ActualTakenE_i;
    assign PHTwriteaddress_o = w_idxE;

    assign BTB_we_o          = w_run & w_validE & w_ctrlE & ActualTakenE_i &
                               (~w_takenE | (w_targetE != ActualTargetE_i));
    assign BTBwriteaddress_o = w_pcE[BTB_IDX_W+1:2];
    assign BTBwritedata_o    = ActualTargetE_i;

    assign GHRreset_o = (r_state == ST_INIT);

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_INIT;
        end else begin
            case (r_state)
                ST_INIT:    r_state <= ST_RUN;
                ST_RUN:     r_state <= w_mispredict ? ST_RECOVER : ST_RUN;
                ST_RECOVER: r_state <= ST_RUN;
                default:    r_state <= ST_INIT;
            endcase
        end
    end

`ifdef BPRED_STATS_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_run && w_validE && w_ctrlE && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_mispredict && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign branchCount_o  = r_branch_cnt;
    assign mispredCount_o = r_mispred_cnt;
`endif

endmodule
